// File: rtl/muldiv_scheduler.sv
// Two-requester front end for one shared iterative multiply/divide unit.
// A round-robin arbiter picks one request. Degenerate cases (rd==0,
// divide by zero, signed overflow) resolve locally. All other requests go
// through the unit's start/done handshake. Exactly one transaction is in
// flight at a time, and the result returns on the winner's response channel.
module muldiv_scheduler #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,
  input  logic [REG_W-1:0] req0_rd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,
  input  logic [REG_W-1:0] req1_rd,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [REG_W-1:0] rsp0_rd,
  output logic [XLEN-1:0]  rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [REG_W-1:0] rsp1_rd,
  output logic [XLEN-1:0]  rsp1_data,
  output logic             unit_start,
  output logic [2:0]       unit_op,
  output logic [XLEN-1:0]  unit_rs1,
  output logic [XLEN-1:0]  unit_rs2,
  input  logic             unit_done,
  input  logic [XLEN-1:0]  unit_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  state_t           state;
  logic             rr_ptr;
  logic             grant_p0;
  logic [2:0]       op_p0;
  logic [XLEN-1:0]  rs1_p0;
  logic [XLEN-1:0]  rs2_p0;
  logic [REG_W-1:0] rd_p0;
  logic [XLEN-1:0]  data_p0;

  logic             win_vld;
  logic             win_id;
  logic [2:0]       win_op;
  logic [XLEN-1:0]  win_rs1;
  logic [XLEN-1:0]  win_rs2;
  logic [REG_W-1:0] win_rd;
  logic [XLEN:0]    fast;
  logic             accept;

  // Returns {hit, data} for requests that can finish without the unit.
  // Checks are ordered so that the first matching case wins.
  function automatic logic [XLEN:0] fast_path(input logic [2:0]       op,
                                              input logic [XLEN-1:0]  rs1,
                                              input logic [XLEN-1:0]  rs2,
                                              input logic [REG_W-1:0] rd);
    logic signed [XLEN-1:0] s_rs1;
    logic signed [XLEN-1:0] s_rs2;
    logic signed [XLEN-1:0] s_min;
    logic                   ovf;
    s_rs1 = $signed(rs1);
    s_rs2 = $signed(rs2);
    s_min = $signed({1'b1, {(XLEN-1){1'b0}}});
    ovf   = (s_rs1 == s_min) && (s_rs2 == -1);
    if (rd == '0)
      return {1'b1, {XLEN{1'b0}}};
    else if ((op == OP_DIV || op == OP_DIVU) && rs2 == '0)
      return {1'b1, {XLEN{1'b1}}};
    else if ((op == OP_REM || op == OP_REMU) && rs2 == '0)
      return {1'b1, rs1};
    else if (op == OP_DIV && ovf)
      return {1'b1, s_min};
    else if (op == OP_REM && ovf)
      return {1'b1, {XLEN{1'b0}}};
    else
      return {1'b0, {XLEN{1'b0}}};
  endfunction

  // Round-robin arbitration: the pointer's requester wins if valid, else the other.
  always_comb begin
    win_vld = req0_valid | req1_valid;
    win_id  = rr_ptr;
    if (rr_ptr ? !req1_valid : !req0_valid)
      win_id = ~rr_ptr;
    win_op  = win_id ? req1_op  : req0_op;
    win_rs1 = win_id ? req1_rs1 : req0_rs1;
    win_rs2 = win_id ? req1_rs2 : req0_rs2;
    win_rd  = win_id ? req1_rd  : req0_rd;
    fast    = fast_path(win_op, win_rs1, win_rs2, win_rd);
    accept  = (state == IDLE) && win_vld;
  end

  assign req0_ready = accept && !win_id;
  assign req1_ready = accept &&  win_id;

  // Transaction sequencer: accept, optional unit round-trip, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      grant_p0 <= 1'b0;
      op_p0    <= '0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
      rd_p0    <= '0;
      data_p0  <= '0;
    end else begin
      case (state)
        // p0: capture the winning request
        IDLE: begin
          if (accept) begin
            grant_p0 <= win_id;
            op_p0    <= win_op;
            rs1_p0   <= win_rs1;
            rs2_p0   <= win_rs2;
            rd_p0    <= win_rd;
            if (fast[XLEN]) begin
              data_p0 <= fast[XLEN-1:0];
              state   <= RESP;
            end else begin
              state   <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (unit_done) begin
            data_p0 <= unit_result;
            state   <= RESP;
          end
        end
        RESP: begin
          if (grant_p0 ? rsp1_ready : rsp0_ready) begin
            rr_ptr <= ~grant_p0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unit_start = (state == ISSUE);
  assign unit_op    = op_p0;
  assign unit_rs1   = rs1_p0;
  assign unit_rs2   = rs2_p0;

  assign rsp0_valid = (state == RESP) && !grant_p0;
  assign rsp1_valid = (state == RESP) &&  grant_p0;
  assign rsp0_rd    = rd_p0;
  assign rsp1_rd    = rd_p0;
  assign rsp0_data  = data_p0;
  assign rsp1_data  = data_p0;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler with a simple behavioural mul unit.
module tb_muldiv_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [4:0]  req0_rd, req1_rd;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [4:0]  rsp0_rd, rsp1_rd;
  logic [31:0] rsp0_data, rsp1_data;
  logic        unit_start, unit_done;
  logic [2:0]  unit_op;
  logic [31:0] unit_rs1, unit_rs2, unit_result;

  int          vectors = 0;
  int          errs    = 0;
  int          start_cnt = 0;
  int          unit_lat = 33;
  int          cnt = 0;
  int          base;
  logic        done_r = 1'b0;
  logic        inj_done = 1'b0;

  always #5 clk = ~clk;

  muldiv_scheduler #(.XLEN(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd(req0_rd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd(req1_rd),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rd(rsp0_rd), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rd(rsp1_rd), .rsp1_data(rsp1_data),
    .unit_start(unit_start), .unit_op(unit_op), .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
    .unit_done(unit_done), .unit_result(unit_result)
  );

  function automatic logic [31:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      3'b000:  return p[31:0];
      3'b011:  return p[63:32];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Shared unit model: done pulse unit_lat cycles after start, cleared by reset.
  always @(posedge clk) begin
    done_r <= 1'b0;
    if (reset) begin
      cnt <= 0;
    end else if (unit_start) begin
      start_cnt   <= start_cnt + 1;
      cnt         <= unit_lat;
      unit_result <= unit_calc(unit_op, unit_rs1, unit_rs2);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) done_r <= 1'b1;
    end
  end
  assign unit_done = done_r | inj_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("rsp_ready_excl", {63'b0, (rsp0_valid | rsp1_valid) & (req0_ready | req1_ready)}, 64'd0);
  endtask

  task automatic drive0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_rd = rd; req0_valid = 1'b1;
  endtask

  task automatic wait_rsp(input bit n, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (n ? rsp1_valid : rsp0_valid) break;
      step();
    end
    check(tag, {63'b0, n ? rsp1_valid : rsp0_valid}, 64'd1);
  endtask

  // Fast-path request on port 0: response must be valid one cycle after accept.
  task automatic fast_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string tag);
    drive0(op, a, b, rd);
    #1;
    check({tag, "_ready"}, {63'b0, req0_ready}, 64'd1);
    step();
    req0_valid = 1'b0;
    check({tag, "_valid"}, {63'b0, rsp0_valid}, 64'd1);
    check({tag, "_data"}, {32'b0, rsp0_data}, {32'b0, exp});
    check({tag, "_rd"}, {59'b0, rsp0_rd}, {59'b0, rd});
    step();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = 0; req0_rs1 = 0; req0_rs2 = 0; req0_rd = 0;
    req1_op = 0; req1_rs1 = 0; req1_rs2 = 0; req1_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rsp0_valid", {63'b0, rsp0_valid}, 64'd0);
    check("rst_rsp1_valid", {63'b0, rsp1_valid}, 64'd0);
    check("rst_unit_start", {63'b0, unit_start}, 64'd0);
    check("rst_unit_rs1", {32'b0, unit_rs1}, 64'd0);
    check("rst_rsp0_data", {32'b0, rsp0_data}, 64'd0);

    // 1: mul 6*7 through the unit
    unit_lat = 33;
    drive0(3'b000, 32'd6, 32'd7, 5'd3);
    #1;
    check("t1_req0_ready", {63'b0, req0_ready}, 64'd1);
    step();
    req0_valid = 1'b0;
    check("t1_unit_start", {63'b0, unit_start}, 64'd1);
    check("t1_unit_rs2", {32'b0, unit_rs2}, 64'd7);
    step();
    check("t1_start_pulse", {63'b0, unit_start}, 64'd0);
    wait_rsp(1'b0, "t1_rsp0_valid");
    check("t1_rsp0_rd", {59'b0, rsp0_rd}, 64'd3);
    check("t1_rsp0_data", {32'b0, rsp0_data}, 64'd42);
    check("t1_rsp1_valid", {63'b0, rsp1_valid}, 64'd0);
    check("t1_starts", start_cnt, 64'd1);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("t1_rsp0_taken", {63'b0, rsp0_valid}, 64'd0);

    // 2: both valid, grants alternate 0,1,0,1
    reset = 1'b1; step(); reset = 1'b0;
    unit_lat = 3;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive0(3'b000, 32'd3, 32'd5, 5'd1);
    req1_op = 3'b011; req1_rs1 = 32'hFFFF_FFFF; req1_rs2 = 32'd2; req1_rd = 5'd2; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_req0_ready", {63'b0, req0_ready}, {63'b0, (k % 2) == 0});
      check("t2_req1_ready", {63'b0, req1_ready}, {63'b0, (k % 2) == 1});
      step();
      check("t2_busy_ready", {62'b0, req0_ready, req1_ready}, 64'd0);
      wait_rsp(k[0], "t2_rsp_valid");
      check("t2_rsp_data", {32'b0, k[0] ? rsp1_data : rsp0_data}, k[0] ? 64'd1 : 64'd15);
      check("t2_rsp_rd", {59'b0, k[0] ? rsp1_rd : rsp0_rd}, k[0] ? 64'd2 : 64'd1);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 3/4: fast paths never start the unit
    base = start_cnt;
    fast_req(3'b101, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, "t3_divu0");
    fast_req(3'b111, 32'd5, 32'd0, 5'd4, 32'd5, "t3_remu0");
    fast_req(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, "t4_div_ovf");
    fast_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, "t4_rem_ovf");
    fast_req(3'b000, 32'd6, 32'd7, 5'd0, 32'd0, "t4_rd0");
    check("t34_no_start", start_cnt, base);

    // 5: back-pressure on rsp0 while req1 waits
    rsp0_ready = 1'b0;
    drive0(3'b101, 32'd5, 32'd0, 5'd7);
    step();
    req0_valid = 1'b0;
    req1_op = 3'b000; req1_rs1 = 32'd4; req1_rs2 = 32'd5; req1_rd = 5'd8; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("t5_rsp0_valid", {63'b0, rsp0_valid}, 64'd1);
      check("t5_rsp0_data", {32'b0, rsp0_data}, 64'hFFFF_FFFF);
      check("t5_rsp0_rd", {59'b0, rsp0_rd}, 64'd7);
      check("t5_req1_blocked", {63'b0, req1_ready}, 64'd0);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    check("t5_req1_ready", {63'b0, req1_ready}, 64'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp(1'b1, "t5_rsp1_valid");
    check("t5_rsp1_data", {32'b0, rsp1_data}, 64'd20);
    check("t5_rsp1_rd", {59'b0, rsp1_rd}, 64'd8);
    step();

    // 6: reset while waiting on the unit, then a stray done
    unit_lat = 20;
    drive0(3'b000, 32'd9, 32'd9, 5'd2);
    step();
    req0_valid = 1'b0;
    step();
    step();
    check("t6_wait_no_rsp", {63'b0, rsp0_valid}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_start", {63'b0, unit_start}, 64'd0);
    check("t6_rst_op", {61'b0, unit_op}, 64'd0);
    check("t6_rst_rs1", {32'b0, unit_rs1}, 64'd0);
    check("t6_rst_rs2", {32'b0, unit_rs2}, 64'd0);
    check("t6_rst_rsp", {62'b0, rsp0_valid, rsp1_valid}, 64'd0);
    check("t6_rst_data", {32'b0, rsp0_data}, 64'd0);
    check("t6_rst_rd", {59'b0, rsp0_rd}, 64'd0);
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t6_no_rsp", {62'b0, rsp0_valid, rsp1_valid}, 64'd0);
      step();
    end
    unit_lat = 3;
    drive0(3'b000, 32'd2, 32'd3, 5'd5);
    #1;
    check("t6_req0_ready", {63'b0, req0_ready}, 64'd1);
    step();
    req0_valid = 1'b0;
    wait_rsp(1'b0, "t6_rsp0_valid");
    check("t6_rsp0_data", {32'b0, rsp0_data}, 64'd6);
    check("t6_rsp0_rd", {59'b0, rsp0_rd}, 64'd5);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
